// File: rtl/wb_collect_pkg.sv
// Shared types for the writeback collector.
// Contents:
//   exe_bundle_t  - one execution result as produced by a functional unit and
//                   retired through writeback to the register file and ROB.
//   OPID_VLD      - bit of opid that marks a bundle as valid.
//   bundle_valid  - helper returning that valid bit.
package wb_collect_pkg;

  localparam int OPID_VLD = 15;

  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] npc;
    logic        misp;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [6:0]  prda;
    logic        prdv;
    logic        ret;
    logic        flush;
  } exe_bundle_t;

  function automatic logic bundle_valid(input exe_bundle_t b);
    return b.opid[OPID_VLD];
  endfunction

endpackage

// File: rtl/wb_select.sv
// Combinational writeback selection.
// Walks the functional units starting at ptr_i (wrapping modulo nfu). From
// each unit it takes the longest run of valid lanes starting at lane 0, and
// stops taking once wwd results have been gathered. Taken bundles are packed
// in visit order into pack_o; unused pack_o lanes are all zero.
// Ports:
//   en_i     - selection enable; when low nothing is claimed
//   ptr_i    - first functional unit to visit
//   resp_i   - per-unit, per-lane execution results
//   claim_o  - per-unit, per-lane claim (contiguous prefix per unit)
//   pack_o   - claimed bundles packed into lanes 0..cnt_o-1
//   cnt_o    - number of claimed bundles
//   last_o   - last unit that received at least one claim
//   any_o    - at least one claim was made
module wb_select
  import wb_collect_pkg::*;
#(
  parameter int nfu = 3,
  parameter int ewd = 4,
  parameter int wwd = 4,
  localparam int PW = (nfu > 1) ? $clog2(nfu) : 1,
  localparam int CW = $clog2(wwd) + 1
) (
  input  logic                     en_i,
  input  logic [PW-1:0]            ptr_i,
  input  exe_bundle_t              resp_i [nfu][ewd],
  output logic [nfu-1:0][ewd-1:0]  claim_o,
  output exe_bundle_t              pack_o [wwd],
  output logic [CW-1:0]            cnt_o,
  output logic [PW-1:0]            last_o,
  output logic                     any_o
);

  localparam int SIW = (wwd > 1) ? $clog2(wwd) : 1;
  localparam logic [CW-1:0] WWD_C = CW'(wwd);
  localparam logic [PW:0]   NFU_C = (PW+1)'(nfu);

  logic [CW-1:0] slots;
  logic [PW:0]   fsum;
  logic [PW-1:0] fu;
  logic          run;

  // 'run' drops at the first invalid lane of a unit (or when slots run out)
  // and stays low for the rest of that unit, which enforces the prefix rule.
  always_comb begin
    claim_o = '0;
    for (int i = 0; i < wwd; i++) pack_o[i] = '0;
    slots  = '0;
    last_o = ptr_i;
    any_o  = 1'b0;
    fsum   = '0;
    fu     = '0;
    run    = 1'b0;
    for (int v = 0; v < nfu; v++) begin
      fsum = {1'b0, ptr_i} + (PW+1)'(v);
      if (fsum >= NFU_C) fsum = fsum - NFU_C;
      fu  = fsum[PW-1:0];
      run = en_i;
      for (int l = 0; l < ewd; l++) begin
        run = run && bundle_valid(resp_i[fu][l]) && (slots < WWD_C);
        if (run) begin
          claim_o[fu][l]          = 1'b1;
          pack_o[slots[SIW-1:0]]  = resp_i[fu][l];
          slots                   = slots + CW'(1);
          last_o                  = fu;
          any_o                   = 1'b1;
        end
      end
    end
    cnt_o = slots;
  end

endmodule

// File: rtl/wb_collect.sv
// Writeback collector: gathers up to wwd valid results per cycle from nfu
// functional-unit result ports and presents them, packed, on a registered
// writeback bus one cycle after they were claimed. A rotating pointer starts
// each cycle's search just past the last unit served so every unit with a
// ready result is reached within nfu-1 cycles.
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-low reset
//   flush   - pipeline flush; suppresses this cycle's selection
//   resp    - per-unit, per-lane results (valid when opid[15] is set)
//   claim   - per-unit, per-lane claim, combinational; units pop on next edge
//   wb      - registered writeback bundles, valid lanes packed from lane 0
//   wb_num  - registered count of valid wb lanes
module wb_collect
  import wb_collect_pkg::*;
#(
  parameter int nfu = 3,
  parameter int ewd = 4,
  parameter int wwd = 4,
  localparam int PW = (nfu > 1) ? $clog2(nfu) : 1,
  localparam int CW = $clog2(wwd) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  exe_bundle_t              resp [nfu][ewd],
  output logic [nfu-1:0][ewd-1:0]  claim,
  output exe_bundle_t              wb [wwd],
  output logic [CW-1:0]            wb_num
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel_last;
  logic          sel_any;
  logic          sel_en;
  exe_bundle_t   wb_d [wwd];
  exe_bundle_t   wb_q [wwd];
  logic [CW-1:0] wb_num_d, wb_num_q;

  // Reset and flush both gate selection off, so claim is zero, nothing is
  // captured for the next cycle and the pointer does not move.
  assign sel_en = rst & ~flush;

  wb_select #(
    .nfu (nfu),
    .ewd (ewd),
    .wwd (wwd)
  ) u_select (
    .en_i    (sel_en),
    .ptr_i   (ptr_q),
    .resp_i  (resp),
    .claim_o (claim),
    .pack_o  (wb_d),
    .cnt_o   (wb_num_d),
    .last_o  (sel_last),
    .any_o   (sel_any)
  );

  // Next search starts one past the last unit that got a claim.
  always_comb begin
    ptr_d = ptr_q;
    if (sel_any) begin
      ptr_d = (sel_last == PW'(nfu - 1)) ? '0 : sel_last + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < wwd; i++) wb_q[i] <= '0;
      wb_num_q <= '0;
      ptr_q    <= '0;
    end else begin
      for (int i = 0; i < wwd; i++) wb_q[i] <= wb_d[i];
      wb_num_q <= wb_num_d;
      ptr_q    <= ptr_d;
    end
  end

  assign wb     = wb_q;
  assign wb_num = wb_num_q;

endmodule

// File: tb/tb_wb_collect.sv
// Testbench for wb_collect: directed scenarios (reset, packing, prefix rule,
// rotation, flush) followed by randomized traffic. A reference model turns
// each cycle's stimulus into an expected claim pattern and an expected
// writeback record; the record is queued and a separate monitor pops and
// compares it against wb/wb_num on the following cycle.
module tb_wb_collect;
  import wb_collect_pkg::*;

  localparam int NFU = 3;
  localparam int EWD = 4;
  localparam int WWD = 4;
  localparam int NW  = $clog2(WWD) + 1;

  typedef logic [NFU-1:0][EWD-1:0] mask_t;

  typedef struct packed {
    exe_bundle_t [WWD-1:0] lane;
    logic [NW-1:0]         num;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  exe_bundle_t stim [NFU][EWD];
  mask_t       claim;
  exe_bundle_t wb [WWD];
  logic [NW-1:0] wb_num;

  int    checks = 0;
  int    errors = 0;
  int    mPtr   = 0;
  logic [14:0] opCnt = '0;
  mask_t lastClaim;
  exp_t  expQ [$];

  wb_collect #(
    .nfu (NFU),
    .ewd (EWD),
    .wwd (WWD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .resp   (stim),
    .claim  (claim),
    .wb     (wb),
    .wb_num (wb_num)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fill every lane with random payload; mask bit set means opid valid.
  task automatic setPattern(input mask_t m);
    for (int f = 0; f < NFU; f++) begin
      for (int l = 0; l < EWD; l++) begin
        stim[f][l].npc   = $urandom;
        stim[f][l].misp  = 1'($urandom);
        stim[f][l].cause = 5'($urandom);
        stim[f][l].tval  = $urandom;
        stim[f][l].prda  = 7'($urandom);
        stim[f][l].prdv  = 1'($urandom);
        stim[f][l].ret   = 1'($urandom);
        stim[f][l].flush = 1'($urandom);
        if (m[f][l]) begin
          stim[f][l].opid = {1'b1, opCnt};
          opCnt++;
        end else begin
          stim[f][l].opid = {1'b0, 15'($urandom)};
        end
      end
    end
  endtask

  // Reference model: visit units from mPtr, take the leading run of valid
  // lanes of each, capped by the writeback slots left.
  task automatic modelStep(input logic en, output mask_t expClaim, output exp_t e);
    exe_bundle_t got [$];
    int total;
    int lastFu;
    int fu;
    int n;
    int take;
    expClaim = '0;
    e        = '0;
    total    = 0;
    lastFu   = -1;
    if (en) begin
      for (int k = 0; k < NFU; k++) begin
        fu = (mPtr + k) % NFU;
        n  = 0;
        while (n < EWD && stim[fu][n].opid[OPID_VLD]) n++;
        take = (n < WWD - total) ? n : WWD - total;
        for (int l = 0; l < take; l++) begin
          expClaim[fu][l] = 1'b1;
          got.push_back(stim[fu][l]);
        end
        total += take;
        if (take > 0) lastFu = fu;
      end
    end
    for (int i = 0; i < got.size(); i++) e.lane[i] = got[i];
    e.num = NW'(total);
    if (lastFu >= 0) mPtr = (lastFu + 1) % NFU;
  endtask

  task automatic applyStimulus(input mask_t m, input logic rstn, input logic fl);
    mask_t expClaim;
    exp_t  e;
    @(posedge clk);
    #2;
    setPattern(m);
    rst   = rstn;
    flush = fl;
    #2;
    modelStep(rstn & ~fl, expClaim, e);
    lastClaim = claim;
    checkOutput("claim", 64'(claim), 64'(expClaim));
    expQ.push_back(e);
    if (!rstn) mPtr = 0;
  endtask

  // Monitor: each cycle compare the registered writeback against the record
  // queued for the previous cycle.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        for (int i = 0; i < WWD; i++) act.lane[i] = wb[i];
        act.num = wb_num;
        checks++;
        if (act !== e) begin
          errors++;
          $display("[TB] FAIL wb: got wb_num=%0d lane0 opid=0x%0h expected wb_num=%0d lane0 opid=0x%0h",
                   act.num, act.lane[0].opid, e.num, e.lane[0].opid);
          for (int i = 0; i < WWD; i++) begin
            if (act.lane[i] !== e.lane[i])
              $display("[TB] FAIL wb_lane%0d: got opid=0x%0h npc=0x%0h expected opid=0x%0h npc=0x%0h",
                       i, act.lane[i].opid, act.lane[i].npc, e.lane[i].opid, e.lane[i].npc);
          end
        end
      end
    end
  end

  initial begin
    mask_t fairExp [6];
    mask_t rm;
    int    n;
    fairExp[0] = 12'h00F; fairExp[1] = 12'h0F0; fairExp[2] = 12'hF00;
    fairExp[3] = 12'h00F; fairExp[4] = 12'h0F0; fairExp[5] = 12'hF00;
    rst   = 1'b0;
    flush = 1'b0;
    setPattern('0);

    // Reset held with every lane valid: nothing may be claimed.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(12'hFFF, 1'b0, 1'b0);
      checkOutput("rst_claim", 64'(lastClaim), 64'h0);
    end

    // Rotation with every unit full, starting from unit 0 after reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(12'hFFF, 1'b1, 1'b0);
      checkOutput("fair_claim", 64'(lastClaim), 64'(fairExp[i]));
    end

    // Unit 0 lanes 0-1, unit 1 lanes 0-2: four slots split two and two.
    applyStimulus(12'h073, 1'b1, 1'b0);
    checkOutput("pack_claim", 64'(lastClaim), 64'h033);
    applyStimulus(12'hFFF, 1'b1, 1'b0);
    checkOutput("ptr_after_pack", 64'(lastClaim), 64'hF00);

    // Hole at lane 1 of unit 0: only lane 0 may be taken.
    applyStimulus(12'h005, 1'b1, 1'b0);
    checkOutput("prefix_claim", 64'(lastClaim), 64'h001);

    // Flush: nothing claimed, pointer stays on unit 1.
    applyStimulus(12'hFFF, 1'b1, 1'b1);
    checkOutput("flush_claim", 64'(lastClaim), 64'h000);
    applyStimulus(12'hFFF, 1'b1, 1'b0);
    checkOutput("flush_ptr_hold", 64'(lastClaim), 64'h0F0);

    // Reset in mid-operation, then restart from unit 0.
    applyStimulus(12'hFFF, 1'b0, 1'b0);
    checkOutput("midrst_claim", 64'(lastClaim), 64'h000);
    applyStimulus(12'h0F3, 1'b1, 1'b0);
    checkOutput("midrst_restart", 64'(lastClaim), 64'h033);

    // Randomized traffic: mostly valid prefixes, occasional holes, flushes
    // and resets.
    for (int c = 0; c < 10000; c++) begin
      rm = '0;
      for (int f = 0; f < NFU; f++) begin
        n = $urandom_range(0, EWD);
        for (int l = 0; l < EWD; l++)
          rm[f][l] = (l < n) || ($urandom_range(0, 7) == 0);
      end
      applyStimulus(rm, ($urandom_range(0, 199) != 0), ($urandom_range(0, 15) == 0));
    end

    applyStimulus('0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    checkOutput("drain", 64'(expQ.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
